serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice first,
// with carry, no-borrow and two's-complement overflow flags and a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             done
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
    logic              carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DIGIT:0]       slice_sum;
    logic                 msb_carry_in;
    logic                 last_slice;
    logic [WIDTH+DIGIT-1:0] s_shift;

    assign slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the sum bit and its two addend bits.
    assign msb_carry_in = slice_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign last_slice   = (cnt_q == CntW'(N - 1));
    assign s_shift      = {slice_sum[DIGIT-1:0], s_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = c_in ^ sub;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Operands shift right so the active slice always sits at bit 0.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = s_shift[WIDTH+DIGIT-1:DIGIT];
                carry_d = slice_sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    state_d = StDone;
                    c_out_d = slice_sum[DIGIT];
                    ovf_d   = msb_carry_in ^ slice_sum[DIGIT];
                    cnt_d   = '0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
